// File: rtl/fir_pkg.sv
// Shared defaults, sequencer state encoding and address width for the FIR MAC sequencer.
package fir_pkg;

    localparam int DATA_IN_WIDTH_DEF  = 16;
    localparam int TAP_WIDTH_DEF      = 32;
    localparam int DATA_OUT_WIDTH_DEF = 64;
    localparam int TAP_COUNT_DEF      = 102;
    localparam int ADDR_WIDTH         = $clog2(TAP_COUNT_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage : fir_pkg

// File: rtl/fir_sample_ring.sv
// Circular sample history: one write per accepted sample, one-cycle clear,
// and a read port addressed as "k samples older than the newest".
module fir_sample_ring #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 102,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         wr_en,
    input  logic signed [DATA_WIDTH-1:0] wr_data,
    input  logic        [ADDR_W-1:0]     rd_offset,
    output logic signed [DATA_WIDTH-1:0] rd_data
);

    logic        [ADDR_W-1:0]     wr_ptr;
    logic        [ADDR_W-1:0]     base;
    logic signed [DATA_WIDTH-1:0] slots [DEPTH];
    logic        [ADDR_W:0]       rd_wide;
    logic        [ADDR_W-1:0]     rd_idx;

    // NOTE: the history lives in flops, not a RAM, because clear must zero every
    // slot in a single cycle; that is also why it is safe to reset it.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            slots  <= '{default: '0};
            wr_ptr <= '0;
            base   <= '0;
        end else if (wr_en) begin
            slots[wr_ptr] <= wr_data;
            base          <= wr_ptr;
            wr_ptr        <= (wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr + ADDR_W'(1);
        end
    end

    // (base - k) mod DEPTH, kept one bit wider so base + DEPTH cannot overflow
    always_comb begin
        if (base >= rd_offset) begin
            rd_wide = {1'b0, base} - {1'b0, rd_offset};
        end else begin
            rd_wide = {1'b0, base} + (ADDR_W + 1)'(DEPTH) - {1'b0, rd_offset};
        end
        rd_idx  = rd_wide[ADDR_W-1:0];
        rd_data = slots[rd_idx];
    end

endmodule : fir_sample_ring

// File: rtl/fir_mac_sequencer.sv
// Single-MAC FIR sequencer: one output per accepted sample, coefficients read
// from an external ROM with one cycle of latency.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = DATA_IN_WIDTH_DEF,
    parameter int TAP_WIDTH      = TAP_WIDTH_DEF,
    parameter int DATA_OUT_WIDTH = DATA_OUT_WIDTH_DEF,
    parameter int TAP_COUNT      = TAP_COUNT_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [DATA_IN_WIDTH-1:0]   in_data,
    input  logic                              clear,
    output logic        [$clog2(TAP_COUNT)-1:0] coef_addr,
    input  logic signed [TAP_WIDTH-1:0]       coef_data,
    output logic                              out_valid,
    output logic signed [DATA_OUT_WIDTH-1:0]  out_data,
    output logic                              busy
);

    localparam int AW     = $clog2(TAP_COUNT);
    localparam int PROD_W = DATA_IN_WIDTH + TAP_WIDTH;

    state_t                            state_q, state_d;
    logic        [AW-1:0]              tap_q;
    logic                              accept;
    logic                              run_last;
    logic                              mac_en_q;
    logic                              ring_clear;
    logic signed [DATA_IN_WIDTH-1:0]   ring_rd;
    logic signed [DATA_IN_WIDTH-1:0]   sample_q;
    logic signed [PROD_W-1:0]          product;
    logic signed [DATA_OUT_WIDTH-1:0]  product_ext;
    logic signed [DATA_OUT_WIDTH-1:0]  acc_q;
    logic signed [DATA_OUT_WIDTH-1:0]  acc_sum;

    assign accept     = in_valid && in_ready;
    assign run_last   = (tap_q == AW'(TAP_COUNT - 1));
    assign ring_clear = clear && (state_q == IDLE);

    fir_sample_ring #(
        .DATA_WIDTH (DATA_IN_WIDTH),
        .DEPTH      (TAP_COUNT),
        .ADDR_W     (AW)
    ) u_ring (
        .clk       (clk),
        .reset     (reset),
        .clear     (ring_clear),
        .wr_en     (accept),
        .wr_data   (in_data),
        .rd_offset (tap_q),
        .rd_data   (ring_rd)
    );

    // NOTE: every sequential block uses <= so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: each always_comb assigns its outputs a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (run_last) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !clear;
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
        coef_addr = (state_q == RUN) ? tap_q : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tap_q <= '0;
        end else if (state_q == RUN) begin
            tap_q <= run_last ? '0 : tap_q + AW'(1);
        end else begin
            tap_q <= '0;
        end
    end

    // The sample fetched in RUN cycle k meets coef_data for tap k one cycle later.
    assign product     = PROD_W'(sample_q) * PROD_W'(coef_data);
    assign product_ext = DATA_OUT_WIDTH'(product);
    assign acc_sum     = acc_q + product_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q <= '0;
            mac_en_q <= 1'b0;
            acc_q    <= '0;
            out_data <= '0;
        end else begin
            mac_en_q <= (state_q == RUN);
            if (state_q == RUN) begin
                sample_q <= ring_rd;
            end
            if (accept) begin
                acc_q <= '0;
            end else if (mac_en_q) begin
                acc_q <= acc_sum;
            end
            // DRAIN carries the last product, so the final sum is captured there
            if (state_q == DRAIN) begin
                out_data <= acc_sum;
            end
        end
    end

endmodule : fir_mac_sequencer

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: a convolution model plus
// literal pins for impulse response, latency, extremes, reset and clear.
module tb_fir_mac_sequencer;

    localparam int T  = 102;
    localparam int DW = 16;
    localparam int TW = 32;
    localparam int OW = 64;
    localparam int AW = $clog2(T);

    logic                 clk      = 1'b0;
    logic                 reset    = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 clear    = 1'b0;
    logic signed [DW-1:0] in_data  = '0;
    logic                 in_ready;
    logic        [AW-1:0] coef_addr;
    logic signed [TW-1:0] coef_data = '0;
    logic                 out_valid;
    logic signed [OW-1:0] out_data;
    logic                 busy;

    logic signed [TW-1:0] rom [T];

    int errors = 0;
    int checks = 0;

    fir_mac_sequencer #(
        .DATA_IN_WIDTH  (DW),
        .TAP_WIDTH      (TW),
        .DATA_OUT_WIDTH (OW),
        .TAP_COUNT      (T)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .clear     (clear),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // External coefficient ROM with one cycle of read latency
    always @(posedge clk) begin
        coef_data <= (int'(coef_addr) < T) ? rom[coef_addr] : '0;
    end

    // Behavioural model: a job is the window of edges from accept to return to idle
    longint hist_m [T];
    bit     job      = 1'b0;
    int     job_e    = 0;
    longint job_y    = 0;
    longint exp_data = 0;
    int     e        = 0;
    int     acc_cnt  = 0;
    int     ov_edge  = -1;

    always @(posedge clk) begin : model
        bit idle_before;
        e++;
        if (reset) begin
            job      = 1'b0;
            exp_data = 0;
            for (int i = 0; i < T; i++) hist_m[i] = 0;
        end else begin
            idle_before = !job;
            if (job && e == job_e + T + 1) exp_data = job_y;
            if (job && e == job_e + T + 2) job = 1'b0;
            if (idle_before) begin
                if (clear) begin
                    for (int i = 0; i < T; i++) hist_m[i] = 0;
                end else if (in_valid) begin
                    for (int i = T - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
                    hist_m[0] = longint'(in_data);
                    job_y = 0;
                    for (int k = 0; k < T; k++) job_y += hist_m[k] * longint'(rom[k]);
                    job   = 1'b1;
                    job_e = e;
                    acc_cnt++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, e, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        if (e > 0) begin
            check("busy",      64'(busy),      64'(job));
            check("in_ready",  64'(in_ready),  64'(!job && !clear));
            check("out_valid", 64'(out_valid), 64'(job && e == job_e + T + 1));
            check("coef_addr", 64'(coef_addr), (job && e - job_e < T) ? 64'(e - job_e) : 64'd0);
            check("out_data",  out_data,       exp_data);
            if (out_valid) ov_edge = e + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        clear    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send(input logic signed [DW-1:0] s);
        int c0  = acc_cnt;
        bit got = 1'b0;
        in_valid = 1'b1;
        in_data  = s;
        for (int i = 0; i < 4 * T && !got; i++) begin
            tick();
            got = (acc_cnt != c0);
        end
        in_valid = 1'b0;
        check("send_accepted", 64'(got), 64'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2 * T && job; i++) tick();
        check("wait_idle", 64'(busy), 64'd0);
    endtask

    task automatic random_rom();
        for (int k = 0; k < T; k++) rom[k] = $urandom;
    endtask

    initial begin : watchdog
        #(90000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int c0;
        random_rom();
        do_reset();

        // Reset state
        check("reset_out_data", out_data, 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);

        // Impulse response and latency, samples sent at the minimum period
        send(16'sd1);
        wait_idle();
        check("latency", 64'(ov_edge - job_e), 64'(T + 2));
        check("impulse_0", out_data, longint'(rom[0]));
        for (int k = 1; k < T; k++) begin
            send(16'sd0);
            wait_idle();
            check("impulse_k", out_data, longint'(rom[k]));
        end
        send(16'sd0);
        wait_idle();
        check("impulse_tail", out_data, 64'd0);

        // Extremes: full history of -32768 against -2^31 coefficients
        for (int k = 0; k < T; k++) rom[k] = 32'sh8000_0000;
        do_reset();
        for (int k = 0; k < T; k++) send(-16'sd32768);
        wait_idle();
        check("extremes", out_data, 64'd7177611906121728);

        // Reset mid-RUN at tap 50 aborts, then impulse behaves normally
        random_rom();
        do_reset();
        send(16'(int'($urandom)));
        repeat (50) tick();
        check("mid_run_addr", 64'(coef_addr), 64'd50);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_out_data", out_data, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        send(16'sd1);
        wait_idle();
        check("post_reset_c0", out_data, longint'(rom[0]));
        send(16'sd0);
        wait_idle();
        check("post_reset_c1", out_data, longint'(rom[1]));
        send(16'sd0);
        wait_idle();
        check("post_reset_c2", out_data, longint'(rom[2]));

        // Clear wins over in_valid and wipes the history of 5s
        random_rom();
        do_reset();
        repeat (5) begin
            send(16'sd5);
            wait_idle();
        end
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'sd9;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_no_accept", 64'(busy), 64'd0);
        send(16'sd1);
        wait_idle();
        check("clear_then_c0", out_data, longint'(rom[0]));

        // Backpressure: in_valid held with changing data while busy
        random_rom();
        c0       = acc_cnt;
        in_valid = 1'b1;
        for (int i = 0; i < 8 * T && acc_cnt - c0 < 3; i++) begin
            in_data = 16'(int'($urandom));
            tick();
        end
        in_valid = 1'b0;
        check("backpressure_accepts", 64'(acc_cnt - c0), 64'd3);
        wait_idle();

        // Randomised traffic with occasional clears
        for (int n = 0; n < 30; n++) begin
            if (n % 10 == 0) random_rom();
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 7) == 0) begin
                clear    = 1'b1;
                in_valid = $urandom_range(0, 1) == 1;
                tick();
                clear    = 1'b0;
                in_valid = 1'b0;
            end
            send(16'(int'($urandom)));
            if (n % 10 == 9) wait_idle();
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fir_mac_sequencer
